// File: rtl/tmd_btb_update_ctrl.sv
// BTB update/maintenance controller: install, remove, allocate, round-robin evict and
// a one-entry-per-cycle flush sweep. Owns the authoritative valid bitmap.

package rv64g_pkg;
    parameter int unsigned XLEN = 64;
endpackage

module tmd_btb_update_ctrl #(
    parameter int unsigned XLEN      = rv64g_pkg::XLEN,
    parameter int unsigned NUM_ENTRY = 128,
    localparam int unsigned IDX_W    = $clog2(NUM_ENTRY)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              upd_valid_i,
    output logic              upd_ready_o,
    input  logic [XLEN-1:0]   upd_curr_addr_i,
    input  logic [XLEN-1:0]   upd_next_addr_i,
    input  logic              upd_is_jump_i,
    input  logic              match_i,
    input  logic [IDX_W-1:0]  match_idx_i,
    input  logic              flush_i,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [XLEN-3:0]   wr_curr_addr_o,
    output logic [XLEN-3:0]   wr_next_addr_o,
    output logic              wr_valid_o,
    output logic              busy_o,
    output logic              flush_done_o,
    output logic [IDX_W:0]    occupancy_o
);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    localparam logic [IDX_W:0]   OCC_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   OCC_FULL = (IDX_W+1)'(NUM_ENTRY);
    localparam logic [IDX_W-1:0] VIC_ONE  = IDX_W'(1);

    state_t                r_state;
    logic [NUM_ENTRY-1:0]  r_valid;
    logic [IDX_W:0]        r_occ;
    logic [IDX_W-1:0]      r_victim;
    logic [IDX_W:0]        r_cnt;
    logic                  r_wr_en;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [XLEN-3:0]       r_wr_curr;
    logic [XLEN-3:0]       r_wr_next;
    logic                  r_wr_valid;
    logic                  r_flush_done;

    logic                  w_hit;
    logic                  w_full;
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_unused;

    assign w_unused = ^{upd_curr_addr_i[1:0], upd_next_addr_i[1:0], w_free_found};

    // A match on an entry the bitmap says is invalid is stale and treated as a miss.
    assign w_hit  = match_i & r_valid[match_idx_i];
    assign w_full = (r_occ == OCC_FULL);

    always_comb begin
        w_free_idx   = '0;
        w_free_found = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_idx   = IDX_W'(i);
                w_free_found = 1'b1;
            end
        end
    end

    assign upd_ready_o    = (r_state == S_IDLE) & ~flush_i;
    assign busy_o         = (r_state == S_FLUSH);
    assign wr_en_o        = r_wr_en;
    assign wr_idx_o       = r_wr_idx;
    assign wr_curr_addr_o = r_wr_curr;
    assign wr_next_addr_o = r_wr_next;
    assign wr_valid_o     = r_wr_valid;
    assign flush_done_o   = r_flush_done;
    assign occupancy_o    = r_occ;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_occ        <= '0;
            r_victim     <= '0;
            r_cnt        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_idx     <= '0;
            r_wr_curr    <= '0;
            r_wr_next    <= '0;
            r_wr_valid   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        // Entry 0 is written in the first FLUSH cycle, so the counter leads by one.
                        r_state    <= S_FLUSH;
                        r_cnt      <= OCC_ONE;
                        r_wr_en    <= 1'b1;
                        r_wr_idx   <= '0;
                        r_wr_valid <= 1'b0;
                        r_wr_curr  <= '0;
                        r_wr_next  <= '0;
                    end else if (upd_valid_i) begin
                        r_wr_curr <= upd_curr_addr_i[XLEN-1:2];
                        r_wr_next <= upd_next_addr_i[XLEN-1:2];
                        if (upd_is_jump_i) begin
                            r_wr_en    <= 1'b1;
                            r_wr_valid <= 1'b1;
                            if (w_hit) begin
                                r_wr_idx <= match_idx_i;
                            end else if (!w_full) begin
                                r_wr_idx            <= w_free_idx;
                                r_valid[w_free_idx] <= 1'b1;
                                r_occ               <= r_occ + OCC_ONE;
                            end else begin
                                r_wr_idx <= r_victim;
                                r_victim <= r_victim + VIC_ONE;
                            end
                        end else if (w_hit) begin
                            r_wr_en              <= 1'b1;
                            r_wr_valid           <= 1'b0;
                            r_wr_idx             <= match_idx_i;
                            r_valid[match_idx_i] <= 1'b0;
                            r_occ                <= r_occ - OCC_ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == OCC_FULL) begin
                        r_state      <= S_IDLE;
                        r_flush_done <= 1'b1;
                        r_valid      <= '0;
                        r_occ        <= '0;
                        r_victim     <= '0;
                    end else begin
                        r_wr_en  <= 1'b1;
                        r_wr_idx <= r_cnt[IDX_W-1:0];
                        r_cnt    <= r_cnt + OCC_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmd_btb_update_ctrl.sv
// Scoreboard bench for tmd_btb_update_ctrl: stimulus pushes expected BTB writes,
// a negedge monitor pops and compares every write the DUT presents.

module tb_tmd_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        upd_valid;
    logic        upd_ready;
    logic [63:0] upd_curr;
    logic [63:0] upd_next;
    logic        upd_is_jump;
    logic        match;
    logic [6:0]  match_idx;
    logic        flush;
    logic        wr_en;
    logic [6:0]  wr_idx;
    logic [61:0] wr_curr;
    logic [61:0] wr_next;
    logic        wr_valid;
    logic        busy;
    logic        flush_done;
    logic [7:0]  occupancy;

    typedef struct packed {
        logic [6:0]  idx;
        logic [61:0] curr;
        logic [61:0] nxt;
        logic        v;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  total  = 0;

    always #5 clk = ~clk;

    tmd_btb_update_ctrl #(.XLEN(64), .NUM_ENTRY(128)) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .upd_valid_i    (upd_valid),
        .upd_ready_o    (upd_ready),
        .upd_curr_addr_i(upd_curr),
        .upd_next_addr_i(upd_next),
        .upd_is_jump_i  (upd_is_jump),
        .match_i        (match),
        .match_idx_i    (match_idx),
        .flush_i        (flush),
        .wr_en_o        (wr_en),
        .wr_idx_o       (wr_idx),
        .wr_curr_addr_o (wr_curr),
        .wr_next_addr_o (wr_next),
        .wr_valid_o     (wr_valid),
        .busy_o         (busy),
        .flush_done_o   (flush_done),
        .occupancy_o    (occupancy)
    );

    always @(negedge clk) begin
        if (!arst && wr_en) begin
            wr_t e;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got idx=%0d valid=%0b curr=0x%0h, expected no write",
                         wr_idx, wr_valid, wr_curr);
            end else begin
                e = exp_q.pop_front();
                if (wr_idx === e.idx && wr_curr === e.curr && wr_next === e.nxt && wr_valid === e.v)
                    passed++;
                else
                    $display("FAIL write: got idx=%0d v=%0b curr=0x%0h next=0x%0h, expected idx=%0d v=%0b curr=0x%0h next=0x%0h",
                             wr_idx, wr_valid, wr_curr, wr_next, e.idx, e.v, e.curr, e.nxt);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [6:0] idx, input logic [63:0] pc, input logic [63:0] tgt, input logic v);
        wr_t e;
        e.idx  = idx;
        e.curr = pc[63:2];
        e.nxt  = tgt[63:2];
        e.v    = v;
        exp_q.push_back(e);
    endtask

    // Issue one update for one cycle; called at posedge+1, returns at the next posedge+1.
    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic jump,
                       input logic m, input logic [6:0] midx, input logic exp_wr, input logic [6:0] eidx);
        upd_valid   = 1'b1;
        upd_curr    = pc;
        upd_next    = tgt;
        upd_is_jump = jump;
        match       = m;
        match_idx   = midx;
        if (exp_wr) push(eidx, pc, tgt, jump);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        match     = 1'b0;
        match_idx = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        arst = 1'b1; upd_valid = 1'b0; upd_curr = '0; upd_next = '0;
        upd_is_jump = 1'b0; match = 1'b0; match_idx = '0; flush = 1'b0;
        #13;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", upd_ready, 1);
        chk("rst_wr_fields", {wr_idx, wr_curr, wr_next, wr_valid}, 0);
        #10 arst = 1'b0;
        @(posedge clk); #1;

        upd(64'h1000, 64'h3000, 1, 0, 0, 1, 0);
        upd(64'h1004, 64'h3004, 1, 0, 0, 1, 1);
        upd(64'h1008, 64'h3008, 1, 0, 0, 1, 2);
        chk("occ_after_3", occupancy, 3);

        upd(64'h1004, 64'h2000, 1, 1, 1, 1, 1);
        chk("occ_jump_hit", occupancy, 3);
        upd(64'h1004, 64'h2000, 0, 1, 1, 1, 1);
        chk("occ_remove", occupancy, 2);
        upd(64'h100C, 64'h300C, 1, 0, 0, 1, 1);
        chk("occ_realloc", occupancy, 3);

        upd(64'h5000, 64'h5100, 0, 0, 0, 0, 0);
        chk("occ_nt_miss", occupancy, 3);
        upd(64'h6000, 64'h6100, 1, 1, 7'd10, 1, 3);
        chk("occ_stale_alloc", occupancy, 4);
        upd(64'h6004, 64'h6100, 0, 1, 7'd20, 0, 0);
        chk("occ_stale_remove", occupancy, 4);

        for (int i = 4; i < 128; i++)
            upd(64'h10000 + 64'(4*i), 64'h20000 + 64'(4*i), 1, 0, 0, 1, 7'(i));
        chk("occ_full", occupancy, 128);
        for (int i = 0; i < 130; i++)
            upd(64'h40000 + 64'(4*i), 64'h50000 + 64'(4*i), 1, 0, 0, 1, 7'(i % 128));
        chk("occ_evict_hold", occupancy, 128);
        upd(64'h10014, 64'h0, 0, 1, 7'd5, 1, 5);
        chk("occ_after_hole", occupancy, 127);
        upd(64'h60000, 64'h60100, 1, 0, 0, 1, 5);
        chk("occ_hole_filled", occupancy, 128);
        upd(64'h60004, 64'h60104, 1, 0, 0, 1, 2);

        flush = 1'b1; upd_valid = 1'b1; upd_curr = 64'h7777; upd_next = 64'h8888; upd_is_jump = 1'b1;
        #1;
        chk("ready_low_on_flush", upd_ready, 0);
        for (int i = 0; i < 128; i++) push(7'(i), 64'h0, 64'h0, 0);
        @(posedge clk); #1;
        flush = 1'b0; upd_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            if (cnt == 2) chk("ready_low_in_flush", upd_ready, 0);
            if (cnt == 10) flush = 1'b1;
            if (cnt == 11) flush = 1'b0;
            if (flush_done) chk("done_during_busy", flush_done, 0);
            @(posedge clk); #1;
        end
        chk("busy_cycles", cnt, 128);
        chk("flush_done_pulse", flush_done, 1);
        chk("occ_after_flush", occupancy, 0);
        upd(64'h7000, 64'h7100, 1, 0, 0, 1, 0);
        chk("done_one_cycle", flush_done, 0);
        chk("occ_post_flush_alloc", occupancy, 1);

        flush = 1'b1;
        for (int i = 0; i < 50; i++) push(7'(i), 64'h0, 64'h0, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (49) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        arst = 1'b1;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_fields", {wr_idx, wr_curr, wr_next, wr_valid, flush_done}, 0);
        #2 arst = 1'b0;
        chk("arst_ready", upd_ready, 1);
        @(posedge clk); #1;
        upd(64'h9000, 64'h9100, 1, 0, 0, 1, 0);
        chk("occ_after_arst", occupancy, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
